// File: rtl/output_queue_pkg.sv
// Shared types and constants for the DAC-side ping-pong output queue.
package output_queue_pkg;
  localparam int DEF_WIDTH = 12;
  localparam logic [DEF_WIDTH-1:0] MIDSCALE = 12'h800;

  typedef logic [DEF_WIDTH-1:0] sample_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PLAY = 1'b1
  } rd_state_t;
endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port, one registered read port, address {bank, addr}.
module frame_bank_ram #(
  parameter int WIDTH = 12,
  parameter int AW    = 10
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  // No reset on contents so the array maps onto block RAM.
  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/output_queue.sv
// Buffers processed frames in a ping-pong RAM and releases one sample per DAC tick.
module output_queue
  import output_queue_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = 512
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  input  logic             last,
  input  logic             dac_tick,
  output logic [WIDTH-1:0] dac_sample,
  output logic             dac_valid,
  output logic             underflow,
  output logic             frame_error
);
  localparam int ADDR_W = $clog2(FRAME_LEN);
  localparam int LEN_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [WIDTH-1:0]  MID       = {1'b1, {(WIDTH-1){1'b0}}};

  rd_state_t               state_q, state_d;
  logic                    wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [1:0]              bank_full_q, bank_full_d;
  logic [1:0][LEN_W-1:0]   bank_len_q, bank_len_d;
  logic                    pend_q, pend_d;
  logic [WIDTH-1:0]        hold_q, hold_d;
  logic                    dac_valid_q, dac_valid_d;
  logic                    underflow_q, underflow_d;
  logic                    frame_error_q, frame_error_d;

  logic                    accept, wr_at_end, commit, rd_issue, rd_at_end;
  logic [WIDTH-1:0]        ram_rdata;

  assign ready     = ~bank_full_q[wr_bank_q];
  assign accept    = valid & ready;
  assign wr_at_end = (wr_addr_q == LAST_ADDR);
  assign commit    = accept & (last | wr_at_end);
  assign rd_issue  = dac_tick & (state_q == RD_PLAY);
  assign rd_at_end = (LEN_W'({1'b0, rd_addr_q}) + LEN_W'(1)) == bank_len_q[rd_bank_q];

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    wr_addr_d     = wr_addr_q;
    rd_bank_d     = rd_bank_q;
    rd_addr_d     = rd_addr_q;
    bank_full_d   = bank_full_q;
    bank_len_d    = bank_len_q;
    hold_d        = hold_q;
    pend_d        = rd_issue;
    dac_valid_d   = dac_tick;
    underflow_d   = dac_tick & (state_q == RD_IDLE);
    // Short frame (last early) or long frame (full bank without last).
    frame_error_d = accept & (last ^ wr_at_end);

    if (pend_q) hold_d = ram_rdata;

    if (accept) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
      if (commit) begin
        bank_full_d[wr_bank_q] = 1'b1;
        bank_len_d[wr_bank_q]  = LEN_W'({1'b0, wr_addr_q}) + LEN_W'(1);
        wr_bank_d              = ~wr_bank_q;
        wr_addr_d              = '0;
      end
    end

    // Only registered fill state is consulted, so a same-cycle commit is not yet playable.
    case (state_q)
      RD_IDLE: if (bank_full_q[rd_bank_q]) state_d = RD_PLAY;
      RD_PLAY: begin
        if (rd_issue) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (rd_at_end) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            rd_addr_d              = '0;
            state_d                = bank_full_q[~rd_bank_q] ? RD_PLAY : RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RD_IDLE;
      wr_bank_q     <= 1'b0;
      wr_addr_q     <= '0;
      rd_bank_q     <= 1'b0;
      rd_addr_q     <= '0;
      bank_full_q   <= '0;
      bank_len_q    <= '0;
      pend_q        <= 1'b0;
      hold_q        <= MID;
      dac_valid_q   <= 1'b0;
      underflow_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      wr_addr_q     <= wr_addr_d;
      rd_bank_q     <= rd_bank_d;
      rd_addr_q     <= rd_addr_d;
      bank_full_q   <= bank_full_d;
      bank_len_q    <= bank_len_d;
      pend_q        <= pend_d;
      hold_q        <= hold_d;
      dac_valid_q   <= dac_valid_d;
      underflow_q   <= underflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  frame_bank_ram #(.WIDTH(WIDTH), .AW(ADDR_W + 1)) u_ram (
    .clock (clock),
    .we    (accept),
    .waddr ({wr_bank_q, wr_addr_q}),
    .wdata (data),
    .re    (rd_issue),
    .raddr ({rd_bank_q, rd_addr_q}),
    .rdata (ram_rdata)
  );

  // The RAM output register doubles as the sample register on play cycles.
  assign dac_sample  = pend_q ? ram_rdata : hold_q;
  assign dac_valid   = dac_valid_q;
  assign underflow   = underflow_q;
  assign frame_error = frame_error_q;
endmodule

// File: tb/tb_output_queue.sv
// Randomized + directed bench for output_queue with a frame-queue reference model and scoreboard.
`timescale 1ns/1ps
module tb_output_queue;
  import output_queue_pkg::*;

  localparam int W  = 12;
  localparam int FL = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] data = '0;
  logic         valid = 1'b0, last = 1'b0, dac_tick = 1'b0;
  logic         ready, dac_valid, underflow, frame_error;
  logic [W-1:0] dac_sample;

  output_queue #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clock(clock), .reset_n(reset_n), .data(data), .valid(valid), .ready(ready),
    .last(last), .dac_tick(dac_tick), .dac_sample(dac_sample), .dac_valid(dac_valid),
    .underflow(underflow), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { int k; sample_t s; bit uf; } dac_exp_t;
  dac_exp_t exp_dac[$];
  int       exp_err[$];

  // Reference model: committed frames in order, with the edge at which each was committed.
  sample_t m_smp[$];
  int      m_len[$];
  int      m_edge[$];
  sample_t m_cur[$];
  int      m_rdpos = 0;
  sample_t m_last_out = MIDSCALE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Drive one cycle of inputs and advance the model for the edge that samples them.
  task automatic step(input bit v, input sample_t d, input bit l, input bit t);
    int k;
    bit rdy;
    k   = cyc + 1;
    rdy = (m_len.size() < 2);
    valid = v; data = d; last = l; dac_tick = t;
    chk("ready", ready, rdy);
    if (t) begin
      if (m_len.size() > 0 && m_edge[0] <= k - 2) begin
        m_last_out = m_smp.pop_front();
        exp_dac.push_back('{k: k, s: m_last_out, uf: 1'b0});
        m_rdpos++;
        if (m_rdpos == m_len[0]) begin
          void'(m_len.pop_front());
          void'(m_edge.pop_front());
          m_rdpos = 0;
        end
      end else begin
        exp_dac.push_back('{k: k, s: m_last_out, uf: 1'b1});
      end
    end
    if (v && rdy) begin
      m_cur.push_back(d);
      if (l || m_cur.size() == FL) begin
        if (l != (m_cur.size() == FL)) exp_err.push_back(k);
        m_len.push_back(m_cur.size());
        m_edge.push_back(k);
        foreach (m_cur[i]) m_smp.push_back(m_cur[i]);
        m_cur.delete();
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input sample_t base, input int n, input bit with_last);
    for (int i = 0; i < n; i++)
      step(1'b1, base + sample_t'(i), with_last && (i == n - 1), 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dac_sample"}, dac_sample, MIDSCALE);
    chk({tag, "_dac_valid"}, dac_valid, 1'b0);
    chk({tag, "_underflow"}, underflow, 1'b0);
    chk({tag, "_frame_error"}, frame_error, 1'b0);
    chk({tag, "_ready"}, ready, 1'b1);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clock) begin
    dac_exp_t e;
    if (reset_n) begin
      if (dac_valid) begin
        if (exp_dac.size() == 0) begin
          checks++; errors++;
          $display("FAIL dac_unexpected: got sample %0h uf %0b expected no output (cycle %0d)",
                   dac_sample, underflow, cyc);
        end else begin
          e = exp_dac.pop_front();
          chk("dac_cycle", cyc, e.k);
          chk("dac_sample", dac_sample, e.s);
          chk("dac_underflow", underflow, e.uf);
        end
      end else if (underflow) begin
        checks++; errors++;
        $display("FAIL underflow_without_valid: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (frame_error) begin
        if (exp_err.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_error_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("frame_error_cycle", cyc, exp_err.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit r;

    // Reset state
    repeat (3) @(posedge clock);
    #1 chk_reset_outputs("in_reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk_reset_outputs("post_reset");

    // Single full frame, slow ticks
    send_frame(12'h100, FL, 1'b1);
    idle(3);
    for (int i = 0; i < FL; i++) begin
      ticks(1);
      idle(3);
    end

    // Drained: tick underflows holding 12'h107
    ticks(1);
    idle(2);
    // Tick coincident with commit, then the following tick, both underflow
    send_frame(12'h300, FL - 1, 1'b0);
    step(1'b1, 12'h307, 1'b1, 1'b1);
    ticks(1);
    ticks(FL);
    idle(2);

    // Two frames with no ticks; ready stalls until the first bank drains
    n = 0;
    for (int i = 0; i < 20; i++) begin
      r = (m_len.size() < 2);
      step(1'b1, 12'h400 + sample_t'(n), (n % FL) == FL - 1, 1'b0);
      if (r) n++;
    end
    for (int i = 0; i < 20 && n < 3 * FL; i++) begin
      r = (m_len.size() < 2);
      step(1'b1, 12'h400 + sample_t'(n), (n % FL) == FL - 1, i < FL);
      if (r) n++;
    end
    ticks(2 * FL + 2);
    idle(2);

    // Short frame then full frame, played back to back
    send_frame(12'h200, 5, 1'b1);
    send_frame(12'h210, FL, 1'b1);
    idle(2);
    ticks(5 + FL);
    // Long frame: no last, forced commit; then a normal frame
    send_frame(12'h220, FL, 1'b0);
    send_frame(12'h230, FL, 1'b1);
    idle(2);
    ticks(2 * FL);
    idle(2);

    // Random traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 2) != 0, sample_t'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) == 0);
    for (int i = 0; i < 40; i++)
      step(m_cur.size() > 0, sample_t'($urandom), 1'b1, 1'b1);
    idle(3);

    // Reset during playback after three samples
    send_frame(12'h500, FL, 1'b1);
    idle(2);
    ticks(3);
    idle(2);
    reset_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    m_smp.delete(); m_len.delete(); m_edge.delete(); m_cur.delete();
    m_rdpos = 0;
    m_last_out = MIDSCALE;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("after_reset_ready", ready, 1'b1);
    ticks(1);
    idle(3);

    chk("dac_queue_drained", exp_dac.size(), 0);
    chk("err_queue_drained", exp_err.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
